mem_resp_demux: RTL and testbench

- Return-path counterpart of the 2:1 request select in front of the shared memory port.
- Records, in issue order, which requester (port zero = instruction fetch, port one = data access) owns each outstanding memory request.
- Steers each in-order memory response to its owner through a one-entry registered output stage.
- Sits between the shared memory response bus and the IF/MEM stage response inputs.

---
 rtl/mem_resp_demux_if.sv | 35 +++
 rtl/mem_resp_demux.sv | 98 +++++++++
 tb/tb_mem_resp_demux.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_demux_if.sv
// Bundle between the shared memory response path and the IF/MEM response inputs.
// slave = demux side, master = surrounding pipeline / memory side.
interface mem_resp_demux_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             req_valid;
   logic             req_sel;
   logic             req_ready;
   logic             resp_valid;
   logic [WIDTH-1:0] resp_data;
   logic             resp_ready;
   logic             zero_valid;
   logic [WIDTH-1:0] zero_data;
   logic             zero_ready;
   logic             one_valid;
   logic [WIDTH-1:0] one_data;
   logic             one_ready;
   logic [CW-1:0]    outstanding;
   logic             err_unexpected;

   modport slave (
      input  req_valid, req_sel, resp_valid, resp_data, zero_ready, one_ready,
      output req_ready, resp_ready, zero_valid, zero_data, one_valid, one_data,
             outstanding, err_unexpected
   );

   modport master (
      output req_valid, req_sel, resp_valid, resp_data, zero_ready, one_ready,
      input  req_ready, resp_ready, zero_valid, zero_data, one_valid, one_data,
             outstanding, err_unexpected
   );
endinterface

// File: rtl/mem_resp_demux.sv
// In-order memory response demux to fetch (port zero) / data (port one); 1-cycle registered output.
// Backpressure: a stalled owner port blocks all responses; req_ready drops when DEPTH requests are outstanding.
module mem_resp_demux #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   mem_resp_demux_if.slave   bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] order_q, order_d;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             out_valid_q, out_valid_d;
   logic             out_dest_q, out_dest_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             err_q, err_d;

   logic full, empty, drain, push, pop;

   always_comb begin
      full  = (count_q == CW'(DEPTH));
      empty = (count_q == '0);
      drain = out_valid_q && (out_dest_q ? bus.one_ready : bus.zero_ready);
      push  = bus.req_valid && !full;
      // Only the head of the output register can free a slot, so ordering is never violated.
      pop   = bus.resp_valid && !empty && (!out_valid_q || drain);

      order_d     = order_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_dest_d  = out_dest_q;
      out_data_d  = out_data_q;
      err_d       = err_q;

      if (push) begin
         order_d[wptr_q] = bus.req_sel;
         wptr_d          = wptr_q + AW'(1);
      end

      if (pop) begin
         out_valid_d = 1'b1;
         out_dest_d  = order_q[rptr_q];
         out_data_d  = bus.resp_data;
         rptr_d      = rptr_q + AW'(1);
      end else if (drain) begin
         out_valid_d = 1'b0;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (bus.resp_valid && empty) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         order_q     <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_dest_q  <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         order_q     <= order_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_dest_q  <= out_dest_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
      end
   end

   assign bus.req_ready      = !full;
   assign bus.resp_ready     = !empty && (!out_valid_q || drain);
   assign bus.zero_valid     = out_valid_q && !out_dest_q;
   assign bus.one_valid      = out_valid_q && out_dest_q;
   assign bus.zero_data      = out_data_q;
   assign bus.one_data       = out_data_q;
   assign bus.outstanding    = count_q;
   assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_mem_resp_demux.sv
// Directed bench for mem_resp_demux: ordering, backpressure, wrap, error flag and async reset.
module tb_mem_resp_demux;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_resp_demux_if #(.WIDTH(32), .DEPTH(4)) bus ();

   mem_resp_demux #(.WIDTH(32), .DEPTH(4)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic sel_a [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic sel_b [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic exp_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_port(input string tag, input logic dest, input logic [31:0] data);
      check_val({tag, "_zv"}, 32'(bus.zero_valid), 32'(!dest));
      check_val({tag, "_ov"}, 32'(bus.one_valid), 32'(dest));
      check_val({tag, "_dat"}, dest ? bus.one_data : bus.zero_data, data);
   endtask

   task automatic push_seq(input logic s0, input logic s1, input logic s2, input logic s3, input int n);
      logic s [4];
      s = '{s0, s1, s2, s3};
      for (int i = 0; i < n; i++) begin
         bus.req_valid = 1'b1;
         bus.req_sel   = s[i];
         step();
      end
      bus.req_valid = 1'b0;
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_sel    = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_data  = '0;
      bus.zero_ready = 1'b1;
      bus.one_ready  = 1'b1;

      // Reset and idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_val("rst_outstanding", 32'(bus.outstanding), 32'd0);
      check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check_val("rst_zero_valid", 32'(bus.zero_valid), 32'd0);
      check_val("rst_one_valid", 32'(bus.one_valid), 32'd0);
      check_val("rst_err", 32'(bus.err_unexpected), 32'd0);
      check_val("rst_data", bus.zero_data, 32'd0);

      // Four requests 0,1,1,0 then back-to-back responses
      push_seq(sel_a[0], sel_a[1], sel_a[2], sel_a[3], 4);
      #1;
      check_val("fill_outstanding", 32'(bus.outstanding), 32'd4);
      check_val("fill_req_ready", 32'(bus.req_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus.resp_valid = 1'b1;
         bus.resp_data  = 32'hA0 + 32'(i);
         #1;
         check_val("a_resp_ready", 32'(bus.resp_ready), 32'd1);
         step();
         if (i == 3) bus.resp_valid = 1'b0;
         check_port("a_out", sel_a[i], 32'hA0 + 32'(i));
         check_val("a_outstanding", 32'(bus.outstanding), 32'(3 - i));
      end
      bus.resp_valid = 1'b0;
      step();
      check_val("a_idle_zv", 32'(bus.zero_valid), 32'd0);
      check_val("a_idle_ov", 32'(bus.one_valid), 32'd0);
      check_val("a_idle_err", 32'(bus.err_unexpected), 32'd0);

      // Full FIFO: push during pop is refused, next push wraps the write pointer
      push_seq(sel_b[0], sel_b[1], sel_b[2], sel_b[3], 4);
      #1;
      check_val("b_full_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid  = 1'b1;
      bus.req_sel    = 1'b0;
      bus.resp_valid = 1'b1;
      bus.resp_data  = 32'hC0;
      #1;
      check_val("b_nobypass_req_ready", 32'(bus.req_ready), 32'd0);
      check_val("b_pop_resp_ready", 32'(bus.resp_ready), 32'd1);
      step();
      bus.req_valid  = 1'b0;
      bus.resp_valid = 1'b0;
      #1;
      check_val("b_after_pop_outstanding", 32'(bus.outstanding), 32'd3);
      check_port("b_c0", 1'b1, 32'hC0);
      bus.req_valid = 1'b1;
      bus.req_sel   = 1'b1;
      #1;
      check_val("b_req_ready", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 1'b0;
      #1;
      check_val("b_wrap_outstanding", 32'(bus.outstanding), 32'd4);
      for (int i = 0; i < 4; i++) begin
         bus.resp_valid = 1'b1;
         bus.resp_data  = 32'hC1 + 32'(i);
         step();
         if (i == 3) bus.resp_valid = 1'b0;
         check_port("b_out", exp_b[i], 32'hC1 + 32'(i));
         check_val("b_outstanding", 32'(bus.outstanding), 32'(3 - i));
      end
      bus.resp_valid = 1'b0;
      step();

      // Blocked port zero stalls the response owned by port one
      push_seq(1'b0, 1'b1, 1'b0, 1'b0, 2);
      bus.zero_ready = 1'b0;
      bus.resp_valid = 1'b1;
      bus.resp_data  = 32'hB0;
      step();
      bus.resp_data = 32'hB1;
      #1;
      check_port("c_b0", 1'b0, 32'hB0);
      check_val("c_stall_resp_ready", 32'(bus.resp_ready), 32'd0);
      step();
      check_port("c_b0_hold", 1'b0, 32'hB0);
      check_val("c_hold_outstanding", 32'(bus.outstanding), 32'd1);
      check_val("c_hold_resp_ready", 32'(bus.resp_ready), 32'd0);
      bus.zero_ready = 1'b1;
      #1;
      check_val("c_release_resp_ready", 32'(bus.resp_ready), 32'd1);
      step();
      bus.resp_valid = 1'b0;
      check_port("c_b1", 1'b1, 32'hB1);
      check_val("c_outstanding", 32'(bus.outstanding), 32'd0);
      step();
      check_val("c_idle_ov", 32'(bus.one_valid), 32'd0);

      // Response with nothing outstanding
      bus.resp_valid = 1'b1;
      bus.resp_data  = 32'hDEAD;
      #1;
      check_val("d_resp_ready", 32'(bus.resp_ready), 32'd0);
      step();
      bus.resp_valid = 1'b0;
      check_val("d_err", 32'(bus.err_unexpected), 32'd1);
      check_val("d_outstanding", 32'(bus.outstanding), 32'd0);
      check_val("d_zv", 32'(bus.zero_valid), 32'd0);
      step();
      check_val("d_err_sticky", 32'(bus.err_unexpected), 32'd1);

      // Push into empty FIFO alongside a response: response waits one cycle
      bus.req_valid  = 1'b1;
      bus.req_sel    = 1'b1;
      bus.resp_valid = 1'b1;
      bus.resp_data  = 32'hE0;
      #1;
      check_val("e_same_cycle_resp_ready", 32'(bus.resp_ready), 32'd0);
      step();
      bus.req_valid = 1'b0;
      check_val("e_outstanding", 32'(bus.outstanding), 32'd1);
      check_val("e_ov_early", 32'(bus.one_valid), 32'd0);
      check_val("e_resp_ready", 32'(bus.resp_ready), 32'd1);
      step();
      bus.resp_valid = 1'b0;
      check_port("e_e0", 1'b1, 32'hE0);
      check_val("e_outstanding_after", 32'(bus.outstanding), 32'd0);
      step();

      // Asynchronous reset with two outstanding and a held response
      push_seq(1'b0, 1'b1, 1'b0, 1'b0, 3);
      bus.zero_ready = 1'b0;
      bus.resp_valid = 1'b1;
      bus.resp_data  = 32'hD0;
      step();
      bus.resp_valid = 1'b0;
      check_port("f_d0", 1'b0, 32'hD0);
      check_val("f_outstanding", 32'(bus.outstanding), 32'd2);
      #2 rst = 1'b1;
      #1;
      check_val("f_rst_outstanding", 32'(bus.outstanding), 32'd0);
      check_val("f_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check_val("f_rst_zv", 32'(bus.zero_valid), 32'd0);
      check_val("f_rst_ov", 32'(bus.one_valid), 32'd0);
      check_val("f_rst_data", bus.zero_data, 32'd0);
      check_val("f_rst_err", 32'(bus.err_unexpected), 32'd0);
      step();
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
